// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, FSM states, instruction fields and status bits shared by the ALU and sequencer
package cpu_pkg;
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;
  localparam logic [4:0] OP_RETX   = 5'd0;
  localparam logic [4:0] OP_RETY   = 5'd1;
  localparam logic [4:0] OP_ADD    = 5'd2;
  localparam logic [4:0] OP_SUB    = 5'd3;
  localparam logic [4:0] OP_CMP    = 5'd4;
  localparam logic [4:0] OP_LSHIFT = 5'd5;
  localparam logic [4:0] OP_LDI    = 5'b11000;
  localparam logic [4:0] OP_JMP    = 5'b11001;
  localparam logic [4:0] OP_JEQ    = 5'b11010;
  localparam logic [4:0] OP_HALT   = 5'b11111;
  localparam int OP_LSB = 11;
  localparam int RD_LSB = 8;
  localparam int RA_LSB = 5;
  localparam int RB_LSB = 2;
  localparam int S_EQ   = 0;
  localparam int S_ZERO = 1;
  function automatic logic is_alu(input logic [4:0] op);
    return op <= OP_LSHIFT;
  endfunction
endpackage

// File: rtl/regfile8x8.sv
// regfile8x8: 8x8 register file, two async read ports, one sync write port, async clear
module regfile8x8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_we,
  input  logic [2:0] i_wa,
  input  logic [7:0] i_wd,
  input  logic [2:0] i_ra,
  input  logic [2:0] i_rb,
  output logic [7:0] o_ra,
  output logic [7:0] o_rb
);
  logic [7:0] r_mem [8];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 8; i++) r_mem[i] <= '0;
    else if (i_we) r_mem[i_wa] <= i_wd;
  assign o_ra = r_mem[i_ra];
  assign o_rb = r_mem[i_rb];
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute controller driving the 8-bit ALU
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [4:0]  alu_aop,
  output logic [7:0]  alu_x,
  output logic [7:0]  alu_y,
  output logic [7:0]  alu_s,
  input  logic [7:0]  alu_o,
  input  logic [7:0]  alu_os,
  output logic [7:0]  pc,
  output logic        halted
);
  state_t      r_state, w_next;
  logic [15:0] r_ir;
  logic [7:0]  r_pc, r_s, r_x, r_y, w_imm, w_rd_a, w_rd_b, w_wd, w_pc_next;
  logic [4:0]  r_aop, w_op;
  logic [2:0]  w_rd, w_ra, w_rb;
  logic        w_we;
  assign w_op  = r_ir[OP_LSB +: 5];
  assign w_rd  = r_ir[RD_LSB +: 3];
  assign w_ra  = r_ir[RA_LSB +: 3];
  assign w_rb  = r_ir[RB_LSB +: 3];
  assign w_imm = r_ir[7:0];
  regfile8x8 u_rf (
    .clk  (clk),
    .rst  (rst),
    .i_we (w_we),
    .i_wa (w_rd),
    .i_wd (w_wd),
    .i_ra (w_ra),
    .i_rb (w_rb),
    .o_ra (w_rd_a),
    .o_rb (w_rd_b)
  );
  always_comb begin
    w_next = r_state == FETCH  ? (imem_ack ? DECODE : FETCH) :
             r_state == DECODE ? EXEC :
             r_state == EXEC   ? (w_op == OP_HALT ? HALT : FETCH) : HALT;
    w_we = r_state == EXEC && ((is_alu(w_op) && w_op != OP_CMP) || w_op == OP_LDI);
    w_wd = w_op == OP_LDI ? w_imm : alu_o;
    w_pc_next = (w_op == OP_JMP || (w_op == OP_JEQ && r_s[S_EQ])) ? w_imm :
                w_op == OP_HALT ? r_pc : r_pc + 8'd1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= FETCH;
      r_ir    <= '0;
      r_pc    <= '0;
      r_s     <= '0;
      r_aop   <= '0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH && imem_ack) r_ir <= imem_data;
      if (r_state == DECODE) begin
        r_aop <= w_op;
        r_x   <= w_rd_a;
        r_y   <= w_rd_b;
      end
      if (r_state == EXEC) begin
        r_pc <= w_pc_next;
        if (is_alu(w_op)) r_s <= alu_os;
      end
    end
  assign imem_req  = r_state == FETCH && !rst;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign alu_aop   = r_aop;
  assign alu_x     = r_x;
  assign alu_y     = r_y;
  assign alu_s     = r_s;
  assign halted    = r_state == HALT;
endmodule
